// File: rtl/pu_seq_if.sv
// Handshake and addressing bundle between the neuron sequencer and the
// operand buffers / PU datapath it controls.
interface pu_seq_if #(
    parameter int ADDR_W = 4,
    parameter int RES_W  = 2
);
    logic              start;
    logic              memRdy;
    logic              ldM;
    logic              ldRes;
    logic              resWr;
    logic [ADDR_W-1:0] wAddr;
    logic [RES_W-1:0]  resAddr;
    logic              rdBank;
    logic              wrBank;
    logic              busy;
    logic              done;

    modport master (
        input  start, memRdy,
        output ldM, ldRes, resWr, wAddr, resAddr, rdBank, wrBank, busy, done
    );

    modport slave (
        output start, memRdy,
        input  ldM, ldRes, resWr, wAddr, resAddr, rdBank, wrBank, busy, done
    );
endinterface

// File: rtl/pu_seq.sv
// Multi-layer neuron schedule sequencer for the 4-input float PU: per neuron it
// loads the multiply stage, then the result stage, then writes aOut back.
module pu_seq #(
    parameter int NEURONS = 4,
    parameter int LAYERS  = 3,
    parameter int ADDR_W  = 4
) (
    input  logic       clk,
    input  logic       rst,
    pu_seq_if.master   bus
);
    localparam int RES_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int LAYER_W = (LAYERS  > 1) ? $clog2(LAYERS)  : 1;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        ADD,
        WB,
        DONE
    } state_t;

    state_t             state_reg;
    logic [RES_W-1:0]   neuron_reg;
    logic [LAYER_W-1:0] layer_reg;
    logic               rd_bank_reg;

    logic last_neuron;
    logic last_layer;

    assign last_neuron = (neuron_reg == RES_W'(NEURONS - 1));
    assign last_layer  = (layer_reg  == LAYER_W'(LAYERS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            neuron_reg  <= '0;
            layer_reg   <= '0;
            rd_bank_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg   <= MUL;
                        neuron_reg  <= '0;
                        layer_reg   <= '0;
                        rd_bank_reg <= 1'b0;
                    end
                end
                MUL: begin
                    // Operands not yet valid: hold everything, address stays put.
                    if (bus.memRdy) begin
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    state_reg <= WB;
                end
                WB: begin
                    if (!last_neuron) begin
                        neuron_reg <= neuron_reg + RES_W'(1);
                        state_reg  <= MUL;
                    end else if (!last_layer) begin
                        // Layer boundary: this layer's outputs become next layer's inputs.
                        neuron_reg  <= '0;
                        layer_reg   <= layer_reg + LAYER_W'(1);
                        rd_bank_reg <= ~rd_bank_reg;
                        state_reg   <= MUL;
                    end else begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so an async reset
    // clears them immediately; ldM additionally qualifies on operand readiness.
    assign bus.ldM     = (state_reg == MUL) && bus.memRdy;
    assign bus.ldRes   = (state_reg == ADD);
    assign bus.resWr   = (state_reg == WB);
    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = (state_reg == DONE);
    assign bus.wAddr   = ADDR_W'(layer_reg) * ADDR_W'(NEURONS) + ADDR_W'(neuron_reg);
    assign bus.resAddr = neuron_reg;
    assign bus.rdBank  = rd_bank_reg;
    assign bus.wrBank  = ~rd_bank_reg;
endmodule

// File: tb/tb_pu_seq.sv
// Directed bench for pu_seq: full runs, stall, start re-assertion, back-to-back
// start and asynchronous abort, checked against a hand-written writeback table.
module tb_pu_seq;
    logic clk;
    logic rst;

    pu_seq_if #(.ADDR_W(4), .RES_W(2)) bus ();

    pu_seq #(.NEURONS(4), .LAYERS(3), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] waddr;
        logic [1:0] resaddr;
        logic       rdbank;
        logic       wrbank;
    } wb_vec_t;

    wb_vec_t tbl [12];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobe exclusivity and ldM qualification, every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((int'(bus.ldM) + int'(bus.ldRes) + int'(bus.resWr) + int'(bus.done)) > 1 ||
                (bus.ldM && !bus.memRdy)) begin
                errors++;
                $display("FAIL excl: ldM=%0b ldRes=%0b resWr=%0b done=%0b memRdy=%0b",
                         bus.ldM, bus.ldRes, bus.resWr, bus.done, bus.memRdy);
            end
        end
    end

    // One run from a start pulse; the start-sampling edge is edge 1.
    // Stall cycles, a mid-run start and a held start are placed by edge number.
    task automatic run(input string tag, input int stall_first, input int stall_last,
                       input int stall_addr, input int restart_edge, input bit hold_start,
                       input int exp_done);
        int  e;
        int  n_ldm;
        int  n_res;
        int  n_wr;
        bit  seen;
        n_ldm = 0;
        n_res = 0;
        n_wr  = 0;
        seen  = 1'b0;
        bus.start  = 1'b1;
        bus.memRdy = 1'b1;
        @(posedge clk);
        e = 1;
        while (e < 200) begin
            #1;
            bus.start  = (e == restart_edge) || (hold_start && e >= exp_done - 1);
            bus.memRdy = !(e >= stall_first && e <= stall_last);
            #1;
            if (bus.ldM)   n_ldm++;
            if (bus.ldRes) n_res++;
            if (e >= stall_first && e <= stall_last) begin
                chk({tag, "_stall_ldM"}, int'(bus.ldM), 0);
                chk({tag, "_stall_wAddr"}, int'(bus.wAddr), stall_addr);
            end
            if (bus.resWr) begin
                $display("%s wb#%0d edge=%0d wAddr=%0d resAddr=%0d rdBank=%0b wrBank=%0b",
                         tag, n_wr, e, bus.wAddr, bus.resAddr, bus.rdBank, bus.wrBank);
                if (n_wr < 12) begin
                    chk({tag, "_wAddr"},   int'(bus.wAddr),   int'(tbl[n_wr].waddr));
                    chk({tag, "_resAddr"}, int'(bus.resAddr), int'(tbl[n_wr].resaddr));
                    chk({tag, "_rdBank"},  int'(bus.rdBank),  int'(tbl[n_wr].rdbank));
                    chk({tag, "_wrBank"},  int'(bus.wrBank),  int'(tbl[n_wr].wrbank));
                end
                n_wr++;
            end
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            e++;
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_done_edge"}, e, exp_done);
        chk({tag, "_n_ldM"}, n_ldm, 12);
        chk({tag, "_n_ldRes"}, n_res, 12);
        chk({tag, "_n_resWr"}, n_wr, 12);
        @(posedge clk);
        #2;
        chk({tag, "_done_pulse"}, int'(bus.done), 0);
        chk({tag, "_idle_busy"}, int'(bus.busy), 0);
        chk({tag, "_idle_wAddr_hold"}, int'(bus.wAddr), 11);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{4'd0, 2'd0, 1'b0, 1'b1};
        end
        tbl[0]  = '{4'd0,  2'd0, 1'b0, 1'b1};
        tbl[1]  = '{4'd1,  2'd1, 1'b0, 1'b1};
        tbl[2]  = '{4'd2,  2'd2, 1'b0, 1'b1};
        tbl[3]  = '{4'd3,  2'd3, 1'b0, 1'b1};
        tbl[4]  = '{4'd4,  2'd0, 1'b1, 1'b0};
        tbl[5]  = '{4'd5,  2'd1, 1'b1, 1'b0};
        tbl[6]  = '{4'd6,  2'd2, 1'b1, 1'b0};
        tbl[7]  = '{4'd7,  2'd3, 1'b1, 1'b0};
        tbl[8]  = '{4'd8,  2'd0, 1'b0, 1'b1};
        tbl[9]  = '{4'd9,  2'd1, 1'b0, 1'b1};
        tbl[10] = '{4'd10, 2'd2, 1'b0, 1'b1};
        tbl[11] = '{4'd11, 2'd3, 1'b0, 1'b1};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.memRdy = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy",    int'(bus.busy),    0);
        chk("rst_done",    int'(bus.done),    0);
        chk("rst_ldM",     int'(bus.ldM),     0);
        chk("rst_ldRes",   int'(bus.ldRes),   0);
        chk("rst_resWr",   int'(bus.resWr),   0);
        chk("rst_wAddr",   int'(bus.wAddr),   0);
        chk("rst_resAddr", int'(bus.resAddr), 0);
        chk("rst_rdBank",  int'(bus.rdBank),  0);
        chk("rst_wrBank",  int'(bus.wrBank),  1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("basic",   -1, -2, 0, -1, 1'b0, 37);
        run("stall",   19, 23, 6, -1, 1'b0, 42);
        run("restart", -1, -2, 0,  7, 1'b0, 37);

        // Back-to-back: start held through DONE relaunches after one IDLE cycle.
        bus.start  = 1'b1;
        bus.memRdy = 1'b1;
        @(posedge clk);
        repeat (36) @(posedge clk);
        #2;
        chk("b2b_done", int'(bus.done), 1);
        @(posedge clk);
        #2;
        chk("b2b_idle_busy", int'(bus.busy), 0);
        @(posedge clk);
        #2;
        chk("b2b_rerun_busy",  int'(bus.busy),  1);
        chk("b2b_rerun_wAddr", int'(bus.wAddr), 0);
        chk("b2b_rerun_ldM",   int'(bus.ldM),   1);
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous abort during ADD of wAddr=5 (edge 17 after start).
        bus.start  = 1'b1;
        bus.memRdy = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("abort_pre_ldRes", int'(bus.ldRes), 1);
        chk("abort_pre_wAddr", int'(bus.wAddr), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ldRes", int'(bus.ldRes), 0);
        chk("abort_busy",  int'(bus.busy),  0);
        chk("abort_wAddr", int'(bus.wAddr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #2;
            chk("abort_quiet_done", int'(bus.done), 0);
            chk("abort_quiet_strobes",
                int'(bus.ldM) + int'(bus.ldRes) + int'(bus.resWr) + int'(bus.busy), 0);
        end

        run("post_reset", -1, -2, 0, -1, 1'b0, 37);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pu_seq.md
Name: pu_seq

Overview:
- Sequencer/initiator that drives the 4-input float processing unit (PU).
- Runs a multi-layer neuron schedule: for each output neuron it waits for operands, pulses ldM, then ldRes, then writes the PU's aOut result back.
- Generates weight-row addresses and selects ping-pong activation banks.
- Sits between the top-level start/done interface, the operand/weight buffers and the PU datapath.

Parameters:
- NEURONS, 4: output neurons per layer.
- LAYERS, 3: layers per run.
- ADDR_W, 4: weight-row address width; requires 2^ADDR_W >= NEURONS*LAYERS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- memRdy  in  1  operand buffers present valid a1..a4/w1..w4 for the current wAddr/rdBank.
- ldM  out  1  PU multiply-register load strobe.
- ldRes  out  1  PU result-register load strobe.
- resWr  out  1  write strobe; stores PU aOut into bank wrBank at resAddr.
- wAddr  out  ADDR_W  weight row, equal to layer*NEURONS + neuron.
- resAddr  out  ceil(log2(NEURONS))  current neuron index.
- rdBank  out  1  activation bank read this layer.
- wrBank  out  1  bank written this layer; always equals ~rdBank.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the run completes.

Behaviour:
- Reset (async, any state): state=IDLE, neuron=0, layer=0, rdBank=0. All strobes, busy and done are 0. wAddr=0, resAddr=0.
- States are IDLE, MUL, ADD, WB, DONE.
- All strobes are Moore outputs decoded from the registered state, except ldM.
- IDLE:
  - start=1 -> MUL; neuron, layer and rdBank are cleared.
  - start=0 -> stay in IDLE.
- MUL:
  - ldM = memRdy (combinational AND of state and memRdy).
  - memRdy=1 -> ADD.
  - memRdy=0 -> stay in MUL; no strobe; wAddr, rdBank and counters hold.
- ADD: ldRes=1 for exactly one cycle -> WB.
- WB: resWr=1 for one cycle, with resAddr=neuron and wrBank=~rdBank.
  - neuron < NEURONS-1 -> neuron+1, go to MUL.
  - Last neuron and layer < LAYERS-1 -> neuron=0, layer+1, rdBank toggles, go to MUL.
  - Last neuron of last layer -> DONE.
- DONE: done=1 and busy=1 for one cycle -> IDLE. Counters hold their final values until the next start.
- Per-neuron latency is 3 cycles (MUL, ADD, WB) with no stalls. Run latency is 3*NEURONS*LAYERS + 1 cycles plus the number of memRdy=0 stall cycles.
- start while busy is ignored. start held high in IDLE begins a new run on the following edge; back-to-back runs are legal.
- ldM and ldRes are never high in the same cycle. resWr never coincides with ldM or ldRes.
- wAddr is derived combinationally from the counters. It is stable from MUL entry through WB.
- Counter wrap: neuron wraps to 0 only at a layer boundary. layer never wraps within a run.
- Reset mid-run aborts immediately. No done is produced, and no further strobes occur until a new start.

Test Plan:
- Default params, memRdy=1 constant, start pulsed one cycle -> done rises on the 37th rising edge after start is sampled. There are exactly 12 ldM, 12 ldRes and 12 resWr pulses. wAddr sequence is 0..11. resAddr sequence is 0,1,2,3 repeated.
- Bank ping-pong, same run -> rdBank=0 for wAddr 0-3, 1 for 4-7, 0 for 8-11. wrBank is the complement in every resWr cycle.
- Stall: hold memRdy=0 for 5 cycles on entry to MUL for wAddr=6 -> no ldM during the stall and wAddr holds at 6. done is delayed by exactly 5 cycles (42nd edge).
- Ignore start: re-assert start at wAddr=2 mid-run -> schedule is unaffected and a single done pulse occurs. Holding start high through DONE begins a second run immediately, with wAddr restarting at 0.
- Async reset asserted during ADD of wAddr=5 -> ldRes, busy and wAddr drop to 0 without waiting for a clock edge. No done occurs. A fresh start then produces the full 12-neuron sequence.
- Mutual exclusion, checked by assertion over all tests -> ldM, ldRes, resWr and done are never co-asserted, and ldM only asserts when memRdy=1.
